// File: rtl/mips_multicycle_core_if.sv
// Shared instruction/data memory bus: word-aligned req/ready handshake with
// arbitrary wait states.
interface mips_multicycle_core_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_ready, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_ready, mem_rdata);
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB over one shared bus,
// halting on BREAK, unsupported encodings or misaligned LW/SW.
module mips_multicycle_core #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  mips_multicycle_core_if.master  bus,
  output logic [ADDR_WIDTH-1:0]   pc_o,
  output logic [31:0]             instr_o,
  output logic                    retire_o,
  output logic                    halted_o,
  output logic                    illegal_o,
  output logic                    misalign_o,
  input  logic [4:0]              dbg_reg_sel_i,
  output logic [31:0]             dbg_reg_data_o
);
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25,
                         F_SLT = 6'h2A, F_BRK = 6'h0D;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d;
  logic                  retire_q, retire_d, halted_q, halted_d;
  logic                  illegal_q, illegal_d, misalign_q, misalign_d;
  logic [31:0][31:0]     rf_q;
  logic                  rf_we;
  logic [4:0]            rf_waddr;

  instr_t                ir;
  logic [31:0]           sext, ea, r_res, pc4_w;
  logic [ADDR_WIDTH-1:0] pc4, br_tgt, j_tgt;
  logic                  is_nop, is_brk, legal;

  assign ir     = instr_t'(ir_q);
  assign sext   = {{16{ir_q[15]}}, ir_q[15:0]};
  assign ea     = a_q + sext;
  assign pc4    = pc_q + ADDR_WIDTH'(4);
  assign pc4_w  = 32'(pc4);
  assign br_tgt = pc4 + ADDR_WIDTH'({sext[29:0], 2'b00});
  assign j_tgt  = ADDR_WIDTH'({pc4_w[31:28], ir_q[25:0], 2'b00});

  // Only the all-zero word is a NOP; funct 0 with other bits set is a shift we don't support.
  assign is_nop = (ir_q == '0);
  assign is_brk = (ir.op == OP_R) && (ir.funct == F_BRK);
  assign legal  = (ir.op == OP_R) ? (is_nop || (ir.funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT}))
                                  : (ir.op inside {OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW});

  always_comb begin
    r_res = '0;
    case (ir.funct)
      F_ADD:   r_res = a_q + b_q;
      F_SUB:   r_res = a_q - b_q;
      F_AND:   r_res = a_q & b_q;
      F_OR:    r_res = a_q | b_q;
      F_SLT:   r_res = {31'b0, $signed(a_q) < $signed(b_q)};
      default: r_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    alu_d      = alu_q;
    retire_d   = 1'b0;
    halted_d   = halted_q;
    illegal_d  = illegal_q;
    misalign_d = misalign_q;
    rf_we      = 1'b0;
    rf_waddr   = (ir.op == OP_R) ? ir.rd : ir.rt;
    case (state_q)
      S_FETCH: if (bus.mem_ready) begin
        ir_d    = bus.mem_rdata;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d = rf_q[ir.rs];
        b_d = rf_q[ir.rt];
        if (is_brk) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (!legal) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (ir.op)
          OP_R: if (is_nop) begin
            pc_d     = pc4;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end else begin
            alu_d   = r_res;
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_d   = ea;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_d = ea;
            if (ea[1:0] != 2'b00) begin
              state_d    = S_HALT;
              halted_d   = 1'b1;
              misalign_d = 1'b1;
            end else begin
              state_d = S_MEM;
            end
          end
          OP_BEQ, OP_BNE: begin
            pc_d     = ((a_q == b_q) == (ir.op == OP_BEQ)) ? br_tgt : pc4;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
          default: begin
            pc_d     = j_tgt;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
        endcase
      end
      S_MEM: if (bus.mem_ready) begin
        if (ir.op == OP_SW) begin
          pc_d     = pc4;
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end else begin
          alu_d   = bus.mem_rdata;
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we    = (rf_waddr != 5'd0);
        pc_d     = pc4;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_q      <= '0;
      retire_q   <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
      rf_q       <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_q      <= alu_d;
      retire_q   <= retire_d;
      halted_q   <= halted_d;
      illegal_q  <= illegal_d;
      misalign_q <= misalign_d;
      if (rf_we) rf_q[rf_waddr] <= alu_q;
    end
  end

  // Request drops combinationally with reset so an in-flight transfer is abandoned at once.
  assign bus.mem_req   = !reset && ((state_q == S_FETCH) || (state_q == S_MEM));
  assign bus.mem_we    = (state_q == S_MEM) && (ir.op == OP_SW);
  assign bus.mem_addr  = (state_q == S_MEM) ? alu_q[ADDR_WIDTH-1:0] : pc_q;
  assign bus.mem_wdata = b_q;

  assign pc_o           = pc_q;
  assign instr_o        = ir_q;
  assign retire_o       = retire_q;
  assign halted_o       = halted_q;
  assign illegal_o      = illegal_q;
  assign misalign_o     = misalign_q;
  assign dbg_reg_data_o = rf_q[dbg_reg_sel_i];
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: memory responder with separate
// fetch/data wait states and per-scenario checking tasks.
module tb_mips_multicycle_core;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  dbg_sel = 5'd0;
  logic [31:0] dbg_data, pc, instr;
  logic        retire, halted, illegal, misalign;

  mips_multicycle_core_if #(.ADDR_WIDTH(32)) bus ();

  mips_multicycle_core #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .pc_o(pc), .instr_o(instr), .retire_o(retire), .halted_o(halted),
    .illegal_o(illegal), .misalign_o(misalign),
    .dbg_reg_sel_i(dbg_sel), .dbg_reg_data_o(dbg_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  int fetch_waits = 0, data_waits = 0, wcnt = 0;
  int tests = 0, fails = 0;

  // Fetches are recognised by address == PC; data transfers use data_waits.
  assign bus.mem_ready = bus.mem_req && (wcnt >= ((bus.mem_addr == pc) ? fetch_waits : data_waits));
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_ready) begin
      wcnt <= 0;
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end else if (bus.mem_req) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic load(input int addr, input logic [31:0] w);
    mem[addr[9:2]] <= w;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    dbg_sel = r;
    #1;
    v = dbg_data;
  endtask

  // Advance until retire or halt; cyc=-1 if the cycle budget expires.
  task automatic run_instr(output int cyc, output int wr_cyc, output int req_cyc, output int ret_cnt);
    cyc = -1; wr_cyc = 0; req_cyc = 0; ret_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.mem_req) req_cyc++;
      if (bus.mem_req && bus.mem_we && bus.mem_addr == 32'h4 && bus.mem_wdata == 32'd10) wr_cyc++;
      if (retire) begin ret_cnt++; cyc = i; break; end
      if (halted) begin cyc = i; break; end
    end
  endtask

  task automatic start_reset();
    reset = 1'b1;
    fetch_waits = 0;
    data_waits = 0;
    clear_mem();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    start_reset();
    load(32'h00, 32'h20010005); load(32'h04, 32'h2002000A);
    load(32'h08, 32'h00221820); load(32'h0C, 32'h00612022);
    load(32'h10, 32'hAC040004); load(32'h14, 32'h8C050004);
    load(32'h18, 32'h10850004); load(32'h2C, 32'h14850004);
    load(32'h30, 32'h00220020); load(32'h34, 32'h08000040);
    load(32'h104, 32'h0023382A); load(32'h108, 32'h8C060002);
    @(negedge clk);
    tests++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin fails++;
      $display("FAIL reset_bus req=%b we=%b expected 0/0", bus.mem_req, bus.mem_we); end
    tests++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin fails++;
      $display("FAIL reset_addr addr=%h wdata=%h expected 0/0", bus.mem_addr, bus.mem_wdata); end
    tests++; if (pc !== 32'h0 || instr !== 32'h0) begin fails++;
      $display("FAIL reset_pc pc=%h instr=%h expected 0/0", pc, instr); end
    tests++; if ({retire, halted, illegal, misalign} !== 4'b0) begin fails++;
      $display("FAIL reset_flags got %b expected 0000", {retire, halted, illegal, misalign}); end
    read_reg(5'd31, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL reset_reg31 got %h expected 0", v); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_arith();
    int c, w, r, n;
    logic [31:0] v;
    logic [31:0] exp_pc [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
    for (int i = 0; i < 4; i++) begin
      run_instr(c, w, r, n);
      tests++; if (c !== 4 || n !== 1) begin fails++;
        $display("FAIL arith_cycles[%0d] got %0d retires=%0d expected 4/1", i, c, n); end
      tests++; if (pc !== exp_pc[i]) begin fails++;
        $display("FAIL arith_pc[%0d] got %h expected %h", i, pc, exp_pc[i]); end
      if (i == 0) begin
        tests++; if (instr !== 32'h20010005) begin fails++;
          $display("FAIL arith_instr got %h expected 20010005", instr); end
      end
    end
    read_reg(5'd3, v);
    tests++; if (v !== 32'd15) begin fails++; $display("FAIL arith_r3 got %0d expected 15", v); end
    read_reg(5'd4, v);
    tests++; if (v !== 32'd10) begin fails++; $display("FAIL arith_r4 got %0d expected 10", v); end
  endtask

  task automatic test_memory();
    int c, w, r, n;
    logic [31:0] v;
    data_waits = 2;
    run_instr(c, w, r, n);
    tests++; if (c !== 6 || n !== 1) begin fails++;
      $display("FAIL sw_cycles got %0d retires=%0d expected 6/1", c, n); end
    tests++; if (w !== 3) begin fails++; $display("FAIL sw_hold got %0d cycles expected 3", w); end
    tests++; if (mem[1] !== 32'd10) begin fails++; $display("FAIL sw_mem got %h expected 0000000a", mem[1]); end
    run_instr(c, w, r, n);
    tests++; if (c !== 7 || n !== 1) begin fails++;
      $display("FAIL lw_cycles got %0d retires=%0d expected 7/1", c, n); end
    read_reg(5'd5, v);
    tests++; if (v !== 32'd10) begin fails++; $display("FAIL lw_r5 got %0d expected 10", v); end
    tests++; if (pc !== 32'h18) begin fails++; $display("FAIL lw_pc got %h expected 18", pc); end
    data_waits = 0;
  endtask

  task automatic test_branch();
    int c, w, r, n;
    logic [31:0] v;
    int          exp_c  [6] = '{3, 3, 4, 3, 3, 4};
    logic [31:0] exp_pc [6] = '{32'h2C, 32'h30, 32'h34, 32'h100, 32'h104, 32'h108};
    for (int i = 0; i < 6; i++) begin
      run_instr(c, w, r, n);
      tests++; if (c !== exp_c[i] || n !== 1 || pc !== exp_pc[i]) begin fails++;
        $display("FAIL branch[%0d] cycles=%0d retires=%0d pc=%h expected %0d/1/%h",
                 i, c, n, pc, exp_c[i], exp_pc[i]); end
      if (i == 2) begin
        read_reg(5'd0, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL r0_write got %h expected 0", v); end
      end
    end
    read_reg(5'd7, v);
    tests++; if (v !== 32'd1) begin fails++; $display("FAIL slt_r7 got %0d expected 1", v); end
  endtask

  task automatic test_misalign();
    int c, w, r, n, reqs;
    logic [31:0] v;
    run_instr(c, w, r, n);
    tests++; if (c !== 3 || n !== 0 || r !== 0) begin fails++;
      $display("FAIL misalign_entry cycles=%0d retires=%0d reqs=%0d expected 3/0/0", c, n, r); end
    tests++; if ({halted, illegal, misalign} !== 3'b101) begin fails++;
      $display("FAIL misalign_flags got %b expected 101", {halted, illegal, misalign}); end
    reqs = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (bus.mem_req || retire) reqs++; end
    tests++; if (reqs !== 0) begin fails++; $display("FAIL misalign_quiet got %0d active cycles expected 0", reqs); end
    read_reg(5'd6, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL misalign_r6 got %h expected 0", v); end
  endtask

  task automatic test_illegal();
    int c, w, r, n, reqs, rets;
    start_reset();
    load(32'h00, 32'hFC000000);
    @(negedge clk);
    reset = 1'b0;
    run_instr(c, w, r, n);
    tests++; if (c !== 2 || n !== 0) begin fails++;
      $display("FAIL illegal_entry cycles=%0d retires=%0d expected 2/0", c, n); end
    tests++; if ({halted, illegal, misalign} !== 3'b110) begin fails++;
      $display("FAIL illegal_flags got %b expected 110", {halted, illegal, misalign}); end
    reqs = 0; rets = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_req) reqs++;
      if (retire) rets++;
    end
    tests++; if (reqs !== 0 || rets !== 0 || halted !== 1'b1 || pc !== 32'h0) begin fails++;
      $display("FAIL illegal_absorb reqs=%0d retires=%0d halted=%b pc=%h expected 0/0/1/0",
               reqs, rets, halted, pc); end
  endtask

  task automatic test_break();
    int c, w, r, n;
    start_reset();
    load(32'h00, 32'h0000000D);
    @(negedge clk);
    reset = 1'b0;
    run_instr(c, w, r, n);
    tests++; if (c !== 2 || n !== 0 || {halted, illegal, misalign} !== 3'b100) begin fails++;
      $display("FAIL break cycles=%0d retires=%0d flags=%b expected 2/0/100",
               c, n, {halted, illegal, misalign}); end
  endtask

  task automatic test_reset_mid_fetch();
    int c, w, r, n;
    logic [31:0] v;
    start_reset();
    load(32'h00, 32'h20010005);
    @(negedge clk);
    reset = 1'b0;
    run_instr(c, w, r, n);
    tests++; if (c !== 4 || pc !== 32'h4) begin fails++;
      $display("FAIL midrst_pre cycles=%0d pc=%h expected 4/4", c, pc); end
    fetch_waits = 100;
    @(negedge clk);
    @(negedge clk);
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_ready !== 1'b0 || bus.mem_addr !== 32'h4) begin fails++;
      $display("FAIL midrst_stall req=%b ready=%b addr=%h expected 1/0/4",
               bus.mem_req, bus.mem_ready, bus.mem_addr); end
    #2 reset = 1'b1;
    #1;
    tests++; if (bus.mem_req !== 1'b0 || pc !== 32'h0) begin fails++;
      $display("FAIL midrst_async req=%b pc=%h expected 0/0", bus.mem_req, pc); end
    read_reg(5'd1, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL midrst_regs r1=%h expected 0", v); end
    @(negedge clk);
    reset = 1'b0;
    fetch_waits = 0;
    #1;
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0 || bus.mem_we !== 1'b0) begin fails++;
      $display("FAIL midrst_refetch req=%b addr=%h we=%b expected 1/0/0",
               bus.mem_req, bus.mem_addr, bus.mem_we); end
    run_instr(c, w, r, n);
    read_reg(5'd1, v);
    tests++; if (c !== 4 || pc !== 32'h4 || v !== 32'd5) begin fails++;
      $display("FAIL midrst_rerun cycles=%0d pc=%h r1=%0d expected 4/4/5", c, pc, v); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_memory();
    test_branch();
    test_misalign();
    test_illegal();
    test_break();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
